// File: rtl/branch_predict_resolve_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_resolve_pkg
// Description : Shared definitions for the branch predictor / resolver.
//               Holds the branch-type codes, the 2-bit counter states, the
//               PC index offset and two small helpers. The helpers test for a
//               conditional branch and step a saturating counter.
// Revision    : 1.0  initial release
// ============================================================================
package branch_predict_resolve_pkg;

   // Branch-type encodings shared with the decoder. Code 7 is undefined.
   localparam logic [2:0] BR_NOBRANCH = 3'd0;
   localparam logic [2:0] BR_BEQ      = 3'd1;
   localparam logic [2:0] BR_BNE      = 3'd2;
   localparam logic [2:0] BR_BLT      = 3'd3;
   localparam logic [2:0] BR_BLTU     = 3'd4;
   localparam logic [2:0] BR_BGE      = 3'd5;
   localparam logic [2:0] BR_BGEU     = 3'd6;

   // 2-bit saturating counter states. The MSB is the taken prediction.
   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   // Instructions are word aligned, so the table index starts at PC bit 2.
   localparam int IDX_LSB = 2;

   function automatic logic is_cond_branch(input logic [2:0] br_type);
      return (br_type >= BR_BEQ) && (br_type <= BR_BGEU);
   endfunction

   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      nxt = ctr;
      if (taken && (ctr != CTR_ST))
         nxt = ctr + 2'd1;
      else if (!taken && (ctr != CTR_SNT))
         nxt = ctr - 2'd1;
      return nxt;
   endfunction

endpackage : branch_predict_resolve_pkg
`default_nettype wire

// File: rtl/branch_predict_resolve_cmp.sv
`default_nettype none
// ============================================================================
// Module      : branch_cmp
// Description : Combinational RV32I branch comparator. Covers BEQ, BNE,
//               BLT, BGE, BLTU and BGEU. NOBRANCH and undefined codes give
//               not-taken.
// Ports       : i_br_type  branch-type code
//               i_op1      rs1 value
//               i_op2      rs2 value
//               o_taken    compare outcome
// Revision    : 1.0  initial release
// ============================================================================
module branch_cmp
   import branch_predict_resolve_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      i_br_type,
   input  logic [XLEN-1:0] i_op1,
   input  logic [XLEN-1:0] i_op2,
   output logic            o_taken
);

   logic w_eq;
   logic w_lt_s;
   logic w_lt_u;

   assign w_eq   = (i_op1 == i_op2);
   assign w_lt_s = ($signed(i_op1) < $signed(i_op2));
   assign w_lt_u = (i_op1 < i_op2);

   always_comb begin
      o_taken = 1'b0;
      case (i_br_type)
         BR_BEQ:  o_taken = w_eq;
         BR_BNE:  o_taken = !w_eq;
         BR_BLT:  o_taken = w_lt_s;
         BR_BGE:  o_taken = !w_lt_s;
         BR_BLTU: o_taken = w_lt_u;
         BR_BGEU: o_taken = !w_lt_u;
         default: o_taken = 1'b0;
      endcase
   end

endmodule : branch_cmp
`default_nettype wire

// File: rtl/branch_predict_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_resolve
// Description : Combined branch predictor and resolver for the RV32I pipeline.
//               The IF stage reads a direct-mapped table of 2-bit counters
//               with a tag and target in each entry. The EX stage resolves the
//               branch, flags a misprediction, supplies the corrected PC and
//               trains the table. Branch and mispredict counters wrap around.
// Ports       : CPU_CLK, CPU_RST_N             clock, sync active-low reset
//               PCF -> PredTakenF, PredTargetF  fetch-stage prediction
//               ValidE, BranchTypeE, Operand1/2, PCE, BrTargetE,
//               PredTakenE, PredTargetE         EX-stage resolve inputs
//               BranchE, MispredictE, CorrectPCE resolve outputs
//               BranchCnt, MispredCnt           performance counters
// Revision    : 1.0  initial release
// ============================================================================
module branch_predict_resolve
   import branch_predict_resolve_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ENTRIES  = 64,
   parameter int TAG_BITS = 8,
   parameter int CNT_W    = 32
) (
   input  logic             CPU_CLK,
   input  logic             CPU_RST_N,
   input  logic [XLEN-1:0]  PCF,
   output logic             PredTakenF,
   output logic [XLEN-1:0]  PredTargetF,
   input  logic             ValidE,
   input  logic [2:0]       BranchTypeE,
   input  logic [XLEN-1:0]  Operand1,
   input  logic [XLEN-1:0]  Operand2,
   input  logic [XLEN-1:0]  PCE,
   input  logic [XLEN-1:0]  BrTargetE,
   input  logic             PredTakenE,
   input  logic [XLEN-1:0]  PredTargetE,
   output logic             BranchE,
   output logic             MispredictE,
   output logic [XLEN-1:0]  CorrectPCE,
   output logic [CNT_W-1:0] BranchCnt,
   output logic [CNT_W-1:0] MispredCnt
);

   localparam int IDX_W   = $clog2(ENTRIES);
   localparam int TAG_LSB = IDX_LSB + IDX_W;
   localparam int TAG_MSB = TAG_LSB + TAG_BITS - 1;

   localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

   // ---------------------------------------------------------------- table
   logic                r_valid  [ENTRIES];
   logic [TAG_BITS-1:0] r_tag    [ENTRIES];
   logic [XLEN-1:0]     r_target [ENTRIES];
   logic [1:0]          r_ctr    [ENTRIES];
   logic [CNT_W-1:0]    r_branch_cnt;
   logic [CNT_W-1:0]    r_mispred_cnt;

   // ---------------------------------------------------------------- predict
   logic [IDX_W-1:0]    w_f_idx;
   logic [TAG_BITS-1:0] w_f_tag;
   logic                w_f_hit;
   logic                w_f_unused;

   assign w_f_idx = PCF[TAG_LSB-1:IDX_LSB];
   assign w_f_tag = PCF[TAG_MSB:TAG_LSB];
   assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);

   // Byte offset and bits above the tag do not take part in the lookup.
   assign w_f_unused = &{PCF[XLEN-1:TAG_MSB+1], PCF[IDX_LSB-1:0]};

   assign PredTakenF  = w_f_hit && r_ctr[w_f_idx][1];
   assign PredTargetF = PredTakenF ? r_target[w_f_idx] : '0;

   // ---------------------------------------------------------------- resolve
   logic                w_cmp_taken;
   logic                w_is_cond;
   logic                w_resolve;
   logic                w_update;
   logic [IDX_W-1:0]    w_e_idx;
   logic [TAG_BITS-1:0] w_e_tag;
   logic                w_e_hit;
   logic                w_e_unused;

   branch_cmp #(
      .XLEN (XLEN)
   ) u_branch_cmp (
      .i_br_type (BranchTypeE),
      .i_op1     (Operand1),
      .i_op2     (Operand2),
      .o_taken   (w_cmp_taken)
   );

   assign w_is_cond = is_cond_branch(BranchTypeE);
   assign w_resolve = ValidE && (BranchTypeE != BR_NOBRANCH);
   assign w_update  = ValidE && w_is_cond;

   assign BranchE = ValidE && w_is_cond && w_cmp_taken;

   // A correct direction is still a mispredict if the cached target is stale.
   assign MispredictE = w_resolve &&
                        ((BranchE != PredTakenE) ||
                         (BranchE && PredTakenE && (PredTargetE != BrTargetE)));

   assign CorrectPCE = BranchE ? BrTargetE : (PCE + c_pc_step);

   assign w_e_idx = PCE[TAG_LSB-1:IDX_LSB];
   assign w_e_tag = PCE[TAG_MSB:TAG_LSB];
   assign w_e_hit = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);

   assign w_e_unused = &{PCE[XLEN-1:TAG_MSB+1], PCE[IDX_LSB-1:0]};

   // ---------------------------------------------------------------- update
   // The fetch read above uses the pre-edge contents, so a same-index write
   // becomes visible to fetch one cycle later. No bypass is needed.
   always_ff @(posedge CPU_CLK) begin
      if (!CPU_RST_N) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= CTR_WNT;
         end
         r_branch_cnt  <= '0;
         r_mispred_cnt <= '0;
      end else if (w_update) begin
         if (w_e_hit) begin
            r_ctr[w_e_idx] <= ctr_next(r_ctr[w_e_idx], BranchE);
            if (BranchE)
               r_target[w_e_idx] <= BrTargetE;
         end else if (BranchE) begin
            // Allocate on a taken miss only. Cold not-taken branches fall
            // through correctly without spending an entry.
            r_valid[w_e_idx]  <= 1'b1;
            r_tag[w_e_idx]    <= w_e_tag;
            r_target[w_e_idx] <= BrTargetE;
            r_ctr[w_e_idx]    <= CTR_WT;
         end
         r_branch_cnt <= r_branch_cnt + CNT_W'(1);
         if (MispredictE)
            r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end
   end

   assign BranchCnt  = r_branch_cnt;
   assign MispredCnt = r_mispred_cnt;

endmodule : branch_predict_resolve
`default_nettype wire

// File: tb/tb_branch_predict_resolve.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_resolve
// Description : Self-checking bench for branch_predict_resolve. Expected
//               values go into a queue when stimulus is driven. They are
//               popped and compared on the falling edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_branch_predict_resolve;

   localparam int XLEN     = 32;
   localparam int ENTRIES  = 64;
   localparam int TAG_BITS = 8;
   localparam int CNT_W    = 4;

   logic             clk;
   logic             rst_n;
   logic [XLEN-1:0]  pcf;
   logic             pred_taken_f;
   logic [XLEN-1:0]  pred_target_f;
   logic             valid_e;
   logic [2:0]       br_type_e;
   logic [XLEN-1:0]  op1;
   logic [XLEN-1:0]  op2;
   logic [XLEN-1:0]  pce;
   logic [XLEN-1:0]  br_target_e;
   logic             pred_taken_e;
   logic [XLEN-1:0]  pred_target_e;
   logic             branch_e;
   logic             mispredict_e;
   logic [XLEN-1:0]  correct_pc_e;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispred_cnt;

   branch_predict_resolve #(
      .XLEN     (XLEN),
      .ENTRIES  (ENTRIES),
      .TAG_BITS (TAG_BITS),
      .CNT_W    (CNT_W)
   ) dut (
      .CPU_CLK     (clk),
      .CPU_RST_N   (rst_n),
      .PCF         (pcf),
      .PredTakenF  (pred_taken_f),
      .PredTargetF (pred_target_f),
      .ValidE      (valid_e),
      .BranchTypeE (br_type_e),
      .Operand1    (op1),
      .Operand2    (op2),
      .PCE         (pce),
      .BrTargetE   (br_target_e),
      .PredTakenE  (pred_taken_e),
      .PredTargetE (pred_target_e),
      .BranchE     (branch_e),
      .MispredictE (mispredict_e),
      .CorrectPCE  (correct_pc_e),
      .BranchCnt   (branch_cnt),
      .MispredCnt  (mispred_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard entry selectors
   localparam int S_PTK = 0;
   localparam int S_PTG = 1;
   localparam int S_BR  = 2;
   localparam int S_MP  = 3;
   localparam int S_CPC = 4;
   localparam int S_BC  = 5;
   localparam int S_MC  = 6;

   typedef struct {
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   m_br   = 0;
   int   m_mp   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v)
         n_pass++;
      else
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         S_PTK:   return {31'd0, pred_taken_f};
         S_PTG:   return pred_target_f;
         S_BR:    return {31'd0, branch_e};
         S_MP:    return {31'd0, mispredict_e};
         S_CPC:   return correct_pc_e;
         S_BC:    return 32'(branch_cnt);
         default: return 32'(mispred_cnt);
      endcase
   endfunction

   function automatic string sel_name(input int sel);
      case (sel)
         S_PTK:   return "PredTakenF";
         S_PTG:   return "PredTargetF";
         S_BR:    return "BranchE";
         S_MP:    return "MispredictE";
         S_CPC:   return "CorrectPCE";
         S_BC:    return "BranchCnt";
         default: return "MispredCnt";
      endcase
   endfunction

   task automatic push(input int sel, input logic [31:0] v);
      exp_t e;
      e.sel = sel;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic drain(input string step);
      exp_t e;
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_val({step, ".", sel_name(e.sel)}, observe(e.sel), e.val);
      end
   endtask

   task automatic push_counts();
      push(S_BC, 32'(m_br));
      push(S_MC, 32'(m_mp));
   endtask

   // Drive one EX-stage branch plus a fetch PC. Push the resolve
   // expectations, then advance the counter model for the coming edge.
   task automatic step(input logic [31:0] f_pc, input logic vld, input logic [2:0] bt,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc_e,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptg,
                       input logic exp_br, input logic exp_mp, input logic [31:0] exp_cpc);
      @(posedge clk);
      #1;
      pcf           = f_pc;
      valid_e       = vld;
      br_type_e     = bt;
      op1           = a;
      op2           = b;
      pce           = pc_e;
      br_target_e   = tgt;
      pred_taken_e  = ptk;
      pred_target_e = ptg;
      push(S_BR, {31'd0, exp_br});
      push(S_MP, {31'd0, exp_mp});
      if (exp_mp)
         push(S_CPC, exp_cpc);
      push_counts();
      if (vld && (bt >= 3'd1) && (bt <= 3'd6)) begin
         m_br = (m_br + 1) % 16;
         if (exp_mp)
            m_mp = (m_mp + 1) % 16;
      end
   endtask

   // Fetch-only cycle: no EX activity, check the prediction for f_pc.
   task automatic peek(input logic [31:0] f_pc, input logic exp_tk, input logic [31:0] exp_tg);
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      valid_e = 1'b0;
      pcf     = f_pc;
      push(S_PTK, {31'd0, exp_tk});
      push(S_PTG, exp_tg);
      push_counts();
      drain("peek");
   endtask

   initial begin
      rst_n = 1'b0; pcf = '0; valid_e = 1'b0; br_type_e = 3'd0; op1 = '0; op2 = '0;
      pce = '0; br_target_e = '0; pred_taken_e = 1'b0; pred_target_e = '0;
      repeat (2) @(posedge clk);

      // Reset state
      peek(32'h100, 1'b0, 32'h0);

      // Compare matrix
      step(32'h100, 1, 3'd3, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h480, 0, 0, 1, 1, 32'h480);
      drain("blt");
      step(32'h100, 1, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h404, 32'h480, 0, 0, 0, 0, 0);
      drain("bltu");
      step(32'h100, 1, 3'd5, 32'd5, 32'd5, 32'h408, 32'h500, 0, 0, 1, 1, 32'h500);
      drain("bge");
      step(32'h100, 1, 3'd2, 32'd7, 32'd7, 32'h40C, 32'h600, 0, 0, 0, 0, 0);
      drain("bne");
      step(32'h100, 1, 3'd6, 32'd1, 32'hFFFF_FFFF, 32'h410, 32'h600, 0, 0, 0, 0, 0);
      drain("bgeu");
      step(32'h100, 1, 3'd0, 32'd3, 32'd3, 32'h414, 32'h600, 0, 0, 0, 0, 0);
      drain("code0");
      // BGE at 0x408 was allocated weakly taken
      peek(32'h408, 1'b1, 32'h500);

      // Loop training; also the same-index read/write on the allocating edge
      step(32'h200, 1, 3'd1, 32'd1, 32'd1, 32'h200, 32'h1F0, 0, 0, 1, 1, 32'h1F0);
      push(S_PTK, 32'd0);
      drain("alloc");
      peek(32'h200, 1'b1, 32'h1F0);
      peek(32'h200 + ENTRIES * 4, 1'b0, 32'h0);
      step(32'h200, 1, 3'd1, 32'd1, 32'd1, 32'h200, 32'h1F0, 1, 32'h1F0, 1, 0, 0);
      drain("taken2");

      // Loop exit: ST -> WT, still predicts taken
      step(32'h200, 1, 3'd1, 32'd1, 32'd2, 32'h200, 32'h1F0, 1, 32'h1F0, 0, 1, 32'h204);
      drain("exit");
      peek(32'h200, 1'b1, 32'h1F0);

      // Target change on hit (WT -> ST, target rewritten)
      step(32'h200, 1, 3'd1, 32'd9, 32'd9, 32'h200, 32'h300, 1, 32'h1F0, 1, 1, 32'h300);
      drain("retarget");
      peek(32'h200, 1'b1, 32'h300);

      // Two not-taken: ST -> WT -> WNT, prediction flips to not taken
      step(32'h200, 1, 3'd1, 32'd1, 32'd2, 32'h200, 32'h300, 1, 32'h300, 0, 1, 32'h204);
      drain("nt1");
      step(32'h200, 1, 3'd1, 32'd1, 32'd2, 32'h200, 32'h300, 1, 32'h300, 0, 1, 32'h204);
      drain("nt2");
      peek(32'h200, 1'b0, 32'h0);

      // Undefined code 7 resolves not-taken
      step(32'h100, 1, 3'd7, 32'd3, 32'd3, 32'h418, 32'h600, 0, 0, 0, 0, 0);
      drain("code7");

      // Reset pulse with a live taken branch; resolve stays combinational
      step(32'h100, 1, 3'd1, 32'd4, 32'd4, 32'h600, 32'h700, 0, 0, 1, 1, 32'h700);
      rst_n = 1'b0;
      drain("rstpulse");
      m_br = 0;
      m_mp = 0;
      peek(32'h600, 1'b0, 32'h0);
      peek(32'h408, 1'b0, 32'h0);

      // Counter wrap at 2^CNT_W
      for (int i = 0; i < 16; i++) begin
         step(32'h100, 1, 3'd2, 32'd1, 32'd2, 32'h800 + 32'(i) * 4, 32'h900, 1, 32'h900, 1, 0, 0);
         drain("wrap");
      end
      peek(32'h100, 1'b0, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_branch_predict_resolve
`default_nettype wire
